// File: rtl/tuner_pkg.sv
// Shared types and constants for the note-detection frame sequencer.
package tuner_pkg;

  // Phases of one analysis window, from accumulator clear to note publish.
  typedef enum logic [2:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    SEARCH,
    WAIT_IDX,
    PUBLISH
  } frame_state_e;

  // ASCII 'A'; channel n is published as note_ascii_base + n.
  localparam logic [7:0] note_ascii_base = 8'd65;

  // ASCII 'X'; published when the search returns an out-of-range channel.
  localparam logic [7:0] note_invalid = 8'd88;

endpackage

// File: rtl/tuner_frame_ctrl_if.sv
// Handshake bundle between the frame sequencer and the sample source,
// the MAC bank, the max-search block and the note display.
interface tuner_frame_ctrl_if;
  logic       valid_i;
  logic       ready_o;
  logic       mac_valid_o;
  logic       mac_clear_o;
  logic       search_valid_o;
  logic       search_ready_i;
  logic       index_valid_i;
  logic [2:0] index_i;
  logic [7:0] note_o;
  logic       update_o;

  // Controller side: signal directions follow the _i/_o suffixes.
  modport slave (
    input  valid_i, search_ready_i, index_valid_i, index_i,
    output ready_o, mac_valid_o, mac_clear_o, search_valid_o, note_o, update_o
  );

  // Environment side: drives the sample, search and index inputs.
  modport master (
    output valid_i, search_ready_i, index_valid_i, index_i,
    input  ready_o, mac_valid_o, mac_clear_o, search_valid_o, note_o, update_o
  );
endinterface

// File: rtl/tuner_frame_ctrl.sv
// Frame sequencer: gates audio samples into the MAC bank for one window,
// drains the MAC pipeline, runs the max search and publishes the winning note.
module tuner_frame_ctrl
  import tuner_pkg::*;
#(
  parameter int window_len_p  = 65536,
  parameter int mac_latency_p = 2,
  parameter int num_notes_p   = 7
) (
  input logic          clk_i,
  input logic          reset_ni,
  tuner_frame_ctrl_if.slave bus
);

  localparam int cnt_w_c   = $clog2(window_len_p);
  localparam int drain_w_c = (mac_latency_p > 1) ? $clog2(mac_latency_p) : 1;
  localparam logic [cnt_w_c-1:0]   cnt_last_c   = cnt_w_c'(window_len_p - 1);
  localparam logic [drain_w_c-1:0] drain_last_c =
    drain_w_c'((mac_latency_p > 0) ? mac_latency_p - 1 : 0);

  frame_state_e         state_q, state_d;
  logic [cnt_w_c-1:0]   cnt_q, cnt_d;
  logic [drain_w_c-1:0] drain_q, drain_d;
  logic [7:0]           note_q, note_d;

  // Channel index to ASCII letter; anything past the last channel shows 'X'.
  function automatic logic [7:0] map_note(input logic [2:0] idx);
    if (int'(idx) < num_notes_p) return note_ascii_base + {5'd0, idx};
    else return note_invalid;
  endfunction

  // State, sample counter, drain counter and published note registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      drain_q <= '0;
      note_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      note_q  <= note_d;
    end
  end

  // Next-state logic; the counter holds at its last value rather than wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    note_d  = note_q;
    case (state_q)
      CLEAR: begin
        cnt_d   = '0;
        drain_d = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (bus.valid_i) begin
          if (cnt_q == cnt_last_c) begin
            drain_d = '0;
            if (mac_latency_p == 0) state_d = SEARCH;
            else state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == drain_last_c) state_d = SEARCH;
        else drain_d = drain_q + 1'b1;
      end
      SEARCH: begin
        if (bus.search_ready_i) state_d = WAIT_IDX;
      end
      WAIT_IDX: begin
        if (bus.index_valid_i) begin
          note_d  = map_note(bus.index_i);
          state_d = PUBLISH;
        end
      end
      PUBLISH: state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Control outputs decode only the registered state.
  always_comb begin
    bus.ready_o        = (state_q == ACCUM);
    bus.mac_clear_o    = (state_q == CLEAR);
    bus.search_valid_o = (state_q == SEARCH);
    bus.update_o       = (state_q == PUBLISH);
    bus.mac_valid_o    = bus.valid_i & (state_q == ACCUM);
    bus.note_o         = note_q;
  end

endmodule

// File: doc/tuner_frame_ctrl.md
# tuner_frame_ctrl

Frame sequencer for the note-detection datapath. It gates the audio sample handshake into the bank of per-note sinusoid generators and MAC accumulators. It counts a fixed analysis window, drains the MAC pipeline, then hands the accumulated magnitudes to the max-search block. When the search returns, it publishes the winning note as an ASCII letter with a one-cycle update strobe, clears the accumulators and starts the next window.

## Interface
Parameters:
- window_len_p, 65536: samples per analysis window; legal range ≥ 2.
- mac_latency_p, 2: cycles from the last accepted sample until the MAC outputs are final; 0 is legal.
- num_notes_p, 7: number of note channels; index values ≥ num_notes_p are invalid.

Ports:
- clk_i  in  1  sole clock; all state changes on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream audio sample valid.
- ready_o  out  1  controller accepts a sample this cycle.
- mac_valid_o  out  1  advances the sinusoids and MACs; equals valid_i & ready_o, combinational.
- mac_clear_o  out  1  synchronous clear for the MAC accumulators and sinusoid phase.
- search_valid_o  out  1  MAC results are final; start the max search.
- search_ready_i  in  1  the max search accepts the start request.
- index_valid_i  in  1  the max search result is valid.
- index_i  in  3  index of the largest channel magnitude.
- note_o  out  8  ASCII note of the last completed window.
- update_o  out  1  one-cycle pulse when note_o changes value or is re-published.

## Operation
- States:
  - CLEAR: mac_clear_o=1, ready_o=0, counter←0. Next state is ACCUM.
  - ACCUM: ready_o=1. Each handshake (valid_i & ready_o) increments the counter. A handshake while counter==window_len_p-1 moves to DRAIN, or straight to SEARCH when mac_latency_p==0. valid_i low holds state and counter.
  - DRAIN: ready_o=0. Counts mac_latency_p cycles, then moves to SEARCH.
  - SEARCH: search_valid_o=1 until search_ready_i is sampled high, then moves to WAIT_IDX. search_valid_o must not drop before acceptance.
  - WAIT_IDX: waits indefinitely for index_valid_i. On index_valid_i it registers note_o and moves to PUBLISH. index_valid_i outside WAIT_IDX is ignored.
  - PUBLISH: update_o=1 for exactly one cycle, then moves to CLEAR.
- Index map: 0→8'd65 'A', 1→66, …, 6→71 'G'. Any index ≥ num_notes_p maps to 8'd88 'X'.
- The counter is $clog2(window_len_p) bits wide. It never wraps, because CLEAR resets it.
- ready_o, search_valid_o, mac_clear_o and update_o are decoded from the registered state only. None of them depends combinationally on inputs.

## Timing
- Reset (reset_ni low, at any time, including mid-window or mid-search):
  - state=CLEAR, counter=0, drain counter=0.
  - note_o=8'd0, update_o=0, ready_o=0, search_valid_o=0.
  - mac_clear_o=1, because it is decoded from CLEAR.
- The first cycle after reset release is CLEAR; ready_o rises on the following cycle.
- Sample acceptance runs at 1 sample per cycle at best; exactly window_len_p handshakes are accepted per window.
- Window turnaround (ready_o low between the last sample of one window and the first of the next): mac_latency_p + 1 (SEARCH, minimum) + 1 (WAIT_IDX, minimum) + 1 (PUBLISH) + 1 (CLEAR) cycles.
- note_o changes in the same cycle that update_o rises, and holds until the next PUBLISH.
- The search handshake is standard valid/ready. index_valid_i arriving in the same cycle as the search acceptance is not consumed; it is only taken in WAIT_IDX.

## Structure
- Shared package tuner_pkg holds:
  - the frame_state_e enum: CLEAR, ACCUM, DRAIN, SEARCH, WAIT_IDX, PUBLISH;
  - the note_ascii_base constant, 8'd65;
  - the note_invalid constant, 8'd88.
- No sub-module. The FSM, counters and index map live in one file.

## Test plan
All scenarios use window_len_p=4 and mac_latency_p=2 unless noted.
- Reset, then continuous valid_i: mac_clear_o is high for 1 cycle, then 4 mac_valid_o pulses, then ready_o is low for 2 DRAIN cycles, then search_valid_o goes high.
- search_ready_i held low for 5 cycles: search_valid_o stays high and ready_o stays low; acceptance on cycle 6 moves to WAIT_IDX.
- index_i=4 with index_valid_i: next cycle update_o=1 and note_o=8'd69 ('E'); the cycle after, mac_clear_o=1.
- index_i=7: note_o=8'd88 ('X'), and update_o still pulses once.
- valid_i toggled 1/0 during ACCUM: exactly 4 handshakes are counted before DRAIN; no mac_valid_o while valid_i is low.
- reset_ni asserted asynchronously mid-DRAIN and mid-WAIT_IDX: outputs go immediately to their reset values; after release, a fresh 4-sample window runs and note_o stays 0 until the first PUBLISH. Repeat with mac_latency_p=0 to confirm ACCUM goes directly to SEARCH.
